// File: rtl/clock_pkg.sv
// Shared types, limits and range check for the clock/stopwatch block.
package clock_pkg;

  localparam int unsigned HW      = 5;
  localparam int unsigned MW      = 6;
  localparam int unsigned SW      = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    C0 = 2'd2,
    C1 = 2'd3
  } view_state_t;

  // True when h:m:s is a legal time of day for the given hour modulus.
  function automatic logic time_in_range(input logic [HW-1:0] h,
                                         input logic [MW-1:0] m,
                                         input logic [SW-1:0] s,
                                         input int unsigned   hour_mod);
    return (32'(h) < hour_mod) && (32'(m) <= MIN_MAX) && (32'(s) <= SEC_MAX);
  endfunction

endpackage

// File: rtl/hms_counter.sv
// Hours:minutes:seconds counter with clear, load and up/down single-step.
module hms_counter
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MOD = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [HW-1:0] load_h,
  input  logic [MW-1:0] load_m,
  input  logic [SW-1:0] load_s,
  output logic [HW-1:0] h,
  output logic [MW-1:0] m,
  output logic [SW-1:0] s,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [HW-1:0] H_MAX = HW'(HOUR_MOD - 1);
  localparam logic [MW-1:0] M_MAX = MW'(MIN_MAX);
  localparam logic [SW-1:0] S_MAX = SW'(SEC_MAX);

  logic [HW-1:0] h_nxt;
  logic [MW-1:0] m_nxt;
  logic [SW-1:0] s_nxt;

  // Priority clr > load > step; all carries/borrows resolve in one edge.
  always_comb begin
    h_nxt = h;
    m_nxt = m;
    s_nxt = s;
    if (clr) begin
      h_nxt = '0;
      m_nxt = '0;
      s_nxt = '0;
    end else if (load) begin
      h_nxt = load_h;
      m_nxt = load_m;
      s_nxt = load_s;
    end else if (en) begin
      if (up) begin
        if (s == S_MAX) begin
          s_nxt = '0;
          if (m == M_MAX) begin
            m_nxt = '0;
            h_nxt = (h == H_MAX) ? '0 : h + HW'(1);
          end else begin
            m_nxt = m + MW'(1);
          end
        end else begin
          s_nxt = s + SW'(1);
        end
      end else begin
        if (s == '0) begin
          s_nxt = S_MAX;
          if (m == '0) begin
            m_nxt = M_MAX;
            h_nxt = (h == '0) ? H_MAX : h - HW'(1);
          end else begin
            m_nxt = m - MW'(1);
          end
        end else begin
          s_nxt = s - SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      m <= '0;
      s <= '0;
    end else begin
      h <= h_nxt;
      m <= m_nxt;
      s <= s_nxt;
    end
  end

  assign at_max  = (h == H_MAX) && (m == M_MAX) && (s == S_MAX);
  assign at_zero = (h == '0) && (m == '0) && (s == '0);

endmodule

// File: rtl/clock_chrono_gen.sv
// Time-of-day clock plus stopwatch with prescaler, alarm and shared display mux.
module clock_chrono_gen
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV            = 1,
  parameter int unsigned HOUR_MOD            = 24,
  parameter int unsigned CHRONO_STOP_AT_ZERO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          startstop,
  input  logic          zera,
  input  logic          ud,
  input  logic          rc,
  input  logic          set_en,
  input  logic [HW-1:0] set_h,
  input  logic [MW-1:0] set_m,
  input  logic [SW-1:0] set_s,
  input  logic          alarm_wr,
  input  logic [HW-1:0] alarm_h,
  input  logic [MW-1:0] alarm_m,
  input  logic          alarm_on,
  input  logic          alarm_ack,
  output logic          tick,
  output logic          nrc,
  output logic [HW-1:0] hora,
  output logic [MW-1:0] minutos,
  output logic [SW-1:0] segundos,
  output logic          alarm,
  output logic          chrono_done
);

  localparam int unsigned   DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic          STOP_Z = (CHRONO_STOP_AT_ZERO != 0);
  localparam logic [HW-1:0] H_MAX  = HW'(HOUR_MOD - 1);
  localparam logic [MW-1:0] M_MAX  = MW'(MIN_MAX);
  localparam logic [SW-1:0] S_MAX  = SW'(SEC_MAX);

  logic [DIV_W-1:0] div_cnt;
  logic [HW-1:0]    clk_h, sw_h, al_h, pre_h;
  logic [MW-1:0]    clk_m, sw_m, al_m, pre_m;
  logic [SW-1:0]    clk_s, sw_s;
  logic             clk_at_max, clk_at_zero, sw_at_max, sw_at_zero;
  logic             set_ok, alarm_ok, sw_step, sw_hold, sw_one, alarm_hit;
  view_state_t      state_q, state_nxt;
  logic             nrc_nxt;
  logic             unused_ok;

  // Seconds prescaler; tick marks the last count of each period.
  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign set_ok   = set_en && time_in_range(set_h, set_m, set_s, HOUR_MOD);
  assign alarm_ok = alarm_wr && time_in_range(alarm_h, alarm_m, SW'(0), HOUR_MOD);

  hms_counter #(.HOUR_MOD(HOUR_MOD)) u_clock (
    .clk     (clk),
    .rst     (rst),
    .en      (tick),
    .up      (1'b1),
    .clr     (1'b0),
    .load    (set_ok),
    .load_h  (set_h),
    .load_m  (set_m),
    .load_s  (set_s),
    .h       (clk_h),
    .m       (clk_m),
    .s       (clk_s),
    .at_max  (clk_at_max),
    .at_zero (clk_at_zero)
  );

  // Stopwatch freezes at zero when configured as a stop-at-zero countdown.
  assign sw_step = tick && startstop;
  assign sw_hold = STOP_Z && !ud && sw_at_zero;
  assign sw_one  = (sw_h == '0) && (sw_m == '0) && (sw_s == SW'(1));

  hms_counter #(.HOUR_MOD(HOUR_MOD)) u_chrono (
    .clk     (clk),
    .rst     (rst),
    .en      (sw_step && !sw_hold),
    .up      (ud),
    .clr     (zera),
    .load    (1'b0),
    .load_h  ('0),
    .load_m  ('0),
    .load_s  ('0),
    .h       (sw_h),
    .m       (sw_m),
    .s       (sw_s),
    .at_max  (sw_at_max),
    .at_zero (sw_at_zero)
  );

  always_ff @(posedge clk) begin
    if (rst)                                                  chrono_done <= 1'b0;
    else if (zera)                                            chrono_done <= 1'b0;
    else if (STOP_Z && sw_step && !ud && (sw_at_zero || sw_one)) chrono_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      al_h <= '0;
      al_m <= '0;
    end else if (alarm_ok) begin
      al_h <= alarm_h;
      al_m <= alarm_m;
    end
  end

  // The tick lands on al_h:al_m:00 exactly when the clock sits one second earlier.
  always_comb begin
    pre_h = al_h;
    pre_m = al_m - MW'(1);
    if (al_m == '0) begin
      pre_m = M_MAX;
      pre_h = (al_h == '0) ? H_MAX : al_h - HW'(1);
    end
  end

  assign alarm_hit = tick && !set_ok && alarm_on &&
                     (clk_h == pre_h) && (clk_m == pre_m) && (clk_s == S_MAX);

  always_ff @(posedge clk) begin
    if (rst)            alarm <= 1'b0;
    else if (alarm_hit) alarm <= 1'b1;
    else if (alarm_ack) alarm <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= R0;
      nrc     <= 1'b1;
    end else begin
      state_q <= state_nxt;
      nrc     <= nrc_nxt;
    end
  end

  // View toggles on each full press/release of rc.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      R0: if (rc)  state_nxt = R1;
      R1: if (!rc) state_nxt = C0;
      C0: if (rc)  state_nxt = C1;
      C1: if (!rc) state_nxt = R0;
      default:     state_nxt = R0;
    endcase
    nrc_nxt = (state_nxt == R0) || (state_nxt == R1);
  end

  always_comb begin
    hora     = nrc ? clk_h : sw_h;
    minutos  = nrc ? clk_m : sw_m;
    segundos = nrc ? clk_s : sw_s;
  end

  assign unused_ok = &{1'b0, clk_at_max, clk_at_zero, sw_at_max};

endmodule

// File: tb/tb_clock_chrono_gen.sv
// Scoreboard bench: prescaled wrap-mode instance (a) and per-cycle stop-at-zero instance (b).
module tb_clock_chrono_gen;

  typedef struct {
    string       name;
    bit          sel;
    logic [20:0] val;
    logic [20:0] msk;
  } exp_t;

  logic clk;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic       a_rst, a_startstop, a_zera, a_ud, a_rc, a_set_en, a_alarm_wr, a_alarm_on, a_alarm_ack;
  logic [4:0] a_set_h, a_alarm_h, a_hora;
  logic [5:0] a_set_m, a_set_s, a_alarm_m, a_min, a_sec;
  logic       a_tick, a_nrc, a_alarm, a_done;

  logic       b_rst, b_startstop, b_zera, b_ud, b_rc;
  logic [4:0] b_hora;
  logic [5:0] b_min, b_sec;
  logic       b_tick, b_nrc, b_alarm, b_done;

  logic [20:0] a_bus, b_bus;
  assign a_bus = {a_tick, a_nrc, a_hora, a_min, a_sec, a_alarm, a_done};
  assign b_bus = {b_tick, b_nrc, b_hora, b_min, b_sec, b_alarm, b_done};

  clock_chrono_gen #(.TICK_DIV(4), .HOUR_MOD(24), .CHRONO_STOP_AT_ZERO(0)) dut_a (
    .clk(clk), .rst(a_rst), .startstop(a_startstop), .zera(a_zera), .ud(a_ud), .rc(a_rc),
    .set_en(a_set_en), .set_h(a_set_h), .set_m(a_set_m), .set_s(a_set_s),
    .alarm_wr(a_alarm_wr), .alarm_h(a_alarm_h), .alarm_m(a_alarm_m),
    .alarm_on(a_alarm_on), .alarm_ack(a_alarm_ack),
    .tick(a_tick), .nrc(a_nrc), .hora(a_hora), .minutos(a_min), .segundos(a_sec),
    .alarm(a_alarm), .chrono_done(a_done)
  );

  clock_chrono_gen #(.TICK_DIV(1), .HOUR_MOD(24), .CHRONO_STOP_AT_ZERO(1)) dut_b (
    .clk(clk), .rst(b_rst), .startstop(b_startstop), .zera(b_zera), .ud(b_ud), .rc(b_rc),
    .set_en(1'b0), .set_h(5'd0), .set_m(6'd0), .set_s(6'd0),
    .alarm_wr(1'b0), .alarm_h(5'd0), .alarm_m(6'd0),
    .alarm_on(1'b0), .alarm_ack(1'b0),
    .tick(b_tick), .nrc(b_nrc), .hora(b_hora), .minutos(b_min), .segundos(b_sec),
    .alarm(b_alarm), .chrono_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    exp_t        e;
    logic [20:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = e.sel ? b_bus : a_bus;
      n_chk++;
      if ((act & e.msk) !== (e.val & e.msk)) begin
        n_fail++;
        $display("FAIL %s: got %h required %h (mask %h) [tick nrc h m s alarm done]",
                 e.name, act & e.msk, e.val & e.msk, e.msk);
      end
    end
  end

  // Field value -1 means "don't care".
  task automatic chk(input string nm, input bit sel, input int tk, input int nr,
                     input int h, input int m, input int s, input int al, input int dn);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.val  = '0;
    e.msk  = '0;
    if (tk >= 0) begin e.val[20]    = tk[0];   e.msk[20]    = 1'b1;  end
    if (nr >= 0) begin e.val[19]    = nr[0];   e.msk[19]    = 1'b1;  end
    if (h  >= 0) begin e.val[18:14] = h[4:0];  e.msk[18:14] = '1;    end
    if (m  >= 0) begin e.val[13:8]  = m[5:0];  e.msk[13:8]  = '1;    end
    if (s  >= 0) begin e.val[7:2]   = s[5:0];  e.msk[7:2]   = '1;    end
    if (al >= 0) begin e.val[1]     = al[0];   e.msk[1]     = 1'b1;  end
    if (dn >= 0) begin e.val[0]     = dn[0];   e.msk[0]     = 1'b1;  end
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic a_load(input int h, input int m, input int s);
    a_set_en = 1'b1;
    a_set_h  = 5'(h);
    a_set_m  = 6'(m);
    a_set_s  = 6'(s);
  endtask

  initial begin
    a_rst = 1'b1; a_startstop = 1'b0; a_zera = 1'b0; a_ud = 1'b1; a_rc = 1'b0;
    a_set_en = 1'b0; a_set_h = '0; a_set_m = '0; a_set_s = '0;
    a_alarm_wr = 1'b0; a_alarm_h = '0; a_alarm_m = '0; a_alarm_on = 1'b0; a_alarm_ack = 1'b0;
    b_rst = 1'b1; b_startstop = 1'b0; b_zera = 1'b0; b_ud = 1'b1; b_rc = 1'b0;

    // ---------------- instance a: TICK_DIV=4, wrap mode ----------------
    step(2);
    chk("a_reset", 0, 0, 1, 0, 0, 0, 0, 0);
    a_rst = 1'b0;
    step(3);  chk("a_tick_c3",  0, 1, 1, 0, 0, 0, 0, 0);
    step(1);  chk("a_sec1",     0, 0, 1, 0, 0, 1, 0, 0);
    step(3);  chk("a_tick_c7",  0, 1, 1, 0, 0, 1, 0, 0);
    step(1);  chk("a_sec2",     0, 0, 1, 0, 0, 2, 0, 0);
    step(3);  chk("a_tick_c11", 0, 1, 1, 0, 0, 2, 0, 0);

    a_load(22, 59, 58);
    step(1);  a_set_en = 1'b0;
    chk("a_load_225958", 0, 0, 1, 22, 59, 58, 0, 0);
    step(4);  chk("a_225959", 0, 0, 1, 22, 59, 59, 0, 0);
    step(4);  chk("a_230000", 0, 0, 1, 23, 0, 0, 0, 0);

    a_load(23, 59, 59);
    step(1);  a_set_en = 1'b0;
    chk("a_load_235959", 0, 0, 1, 23, 59, 59, 0, 0);
    step(3);  chk("a_day_wrap", 0, 0, 1, 0, 0, 0, 0, 0);
    step(3);  chk("a_pre_badload", 0, 1, 1, 0, 0, 0, 0, 0);
    a_load(5, 5, 60);
    step(1);  a_set_en = 1'b0;
    chk("a_badload_ignored", 0, 0, 1, 0, 0, 1, 0, 0);

    a_alarm_wr = 1'b1; a_alarm_h = 5'd7; a_alarm_m = 6'd30; a_alarm_on = 1'b1;
    a_load(7, 29, 59);
    step(1);  a_alarm_wr = 1'b0; a_set_en = 1'b0;
    chk("a_alarm_armed", 0, 0, 1, 7, 29, 59, 0, 0);
    step(2);  chk("a_alarm_pre", 0, 1, 1, 7, 29, 59, 0, 0);
    step(1);  chk("a_alarm_set", 0, 0, 1, 7, 30, 0, 1, 0);
    a_alarm_ack = 1'b1;
    step(1);  a_alarm_ack = 1'b0;
    chk("a_alarm_ack", 0, 0, 1, 7, 30, 0, 0, 0);
    a_load(7, 29, 59);
    step(1);  a_set_en = 1'b0;
    step(1);  a_alarm_ack = 1'b1;
    chk("a_ack_pre", 0, 1, 1, 7, 29, 59, 0, 0);
    step(1);  a_alarm_ack = 1'b0;
    chk("a_set_beats_ack", 0, 0, 1, 7, 30, 0, 1, 0);
    a_alarm_ack = 1'b1;
    step(1);  a_alarm_ack = 1'b0;
    a_load(7, 30, 0);
    step(1);  a_set_en = 1'b0;
    chk("a_load_no_alarm", 0, 0, 1, 7, 30, 0, 0, 0);

    a_rc = 1'b1;
    step(2);  chk("a_rc_held_r1", 0, 0, 1, 7, 30, 1, 0, 0);
    a_rc = 1'b0;
    step(1);  chk("a_view_chrono", 0, 0, 0, 0, 0, 0, 0, 0);
    a_startstop = 1'b1; a_ud = 1'b0;
    step(2);  chk("a_down_pre", 0, 1, 0, 0, 0, 0, 0, 0);
    step(1);  chk("a_down_wrap", 0, 0, 0, 23, 59, 59, 0, 0);
    a_ud = 1'b1;
    step(4);  chk("a_up_wrap", 0, 0, 0, 0, 0, 0, 0, 0);
    a_startstop = 1'b0;
    a_rc = 1'b1;
    step(1);  a_rc = 1'b0;
    step(1);  chk("a_view_clock", 0, 0, 1, 7, 30, 3, 0, 0);

    a_startstop = 1'b1; a_ud = 1'b1;
    step(2);  a_rst = 1'b1;
    step(1);  a_rst = 1'b0; a_startstop = 1'b0;
    chk("a_midcount_rst", 0, 0, 1, 0, 0, 0, 0, 0);
    a_rc = 1'b1;
    step(1);  a_rc = 1'b0;
    step(1);  chk("a_rst_chrono", 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- instance b: TICK_DIV=1, stop-at-zero ----------------
    chk("b_reset", 1, 1, 1, 0, 0, 0, 0, 0);
    b_rst = 1'b0; b_rc = 1'b1;
    step(1);  b_rc = 1'b0;
    step(1);  chk("b_view_chrono", 1, 1, 0, 0, 0, 0, 0, 0);
    b_startstop = 1'b1; b_ud = 1'b0;
    step(1);  chk("b_zero_hold", 1, 1, 0, 0, 0, 0, 0, 1);
    step(1);  chk("b_zero_still", 1, 1, 0, 0, 0, 0, 0, 1);
    b_zera = 1'b1;
    step(1);  b_zera = 1'b0; b_ud = 1'b1;
    chk("b_zera_clears", 1, 1, 0, 0, 0, 0, 0, 0);
    step(2);  b_ud = 1'b0;
    chk("b_up_two", 1, 1, 0, 0, 0, 2, 0, 0);
    step(1);  chk("b_down_one", 1, 1, 0, 0, 0, 1, 0, 0);
    step(1);  chk("b_land_zero", 1, 1, 0, 0, 0, 0, 0, 1);
    b_startstop = 1'b0; b_rst = 1'b1;
    step(1);  b_rst = 1'b0;
    chk("b_rst_done", 1, 1, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_chrono_gen.md
Name: clock_chrono_gen

Overview:
- Parametrised single-clock time-of-day clock plus stopwatch (chronometer) with a shared 3-field display mux.
- Adds to the previous generation:
  - an internal seconds prescaler;
  - synchronous carry enables instead of ripple clocks;
  - settable time and a configurable hour modulus;
  - an alarm, and an optional stop-at-zero countdown.
- Sits between the board clock/buttons and the 7-segment display driver.

Parameters:
- TICK_DIV, 1: clk cycles per second tick (>=1); 1 = count every cycle (simulation).
- HOUR_MOD, 24: hour modulus (12 or 24); hours run 0..HOUR_MOD-1.
- CHRONO_STOP_AT_ZERO, 0: 1 = down-counting stopwatch halts at 00:00:00 and flags done; 0 = wraps.

Ports:
- clk  in  1  single system clock; every flop on posedge clk.
- rst  in  1  synchronous, active-high reset.
- startstop  in  1  level; stopwatch counts on ticks while 1.
- zera  in  1  synchronous stopwatch clear.
- ud  in  1  stopwatch direction: 1 up, 0 down.
- rc  in  1  view button; press+release toggles the view.
- set_en  in  1  load clock time from set_h/set_m/set_s.
- set_h  in  5  hour to load.
- set_m  in  6  minute to load.
- set_s  in  6  second to load.
- alarm_wr  in  1  load alarm time from alarm_h/alarm_m.
- alarm_h  in  5  alarm hour.
- alarm_m  in  6  alarm minute.
- alarm_on  in  1  alarm enable.
- alarm_ack  in  1  clears the alarm flag.
- tick  out  1  one-cycle seconds strobe.
- nrc  out  1  1 = clock view, 0 = stopwatch view.
- hora  out  5  displayed hours.
- minutos  out  6  displayed minutes.
- segundos  out  6  displayed seconds.
- alarm  out  1  sticky alarm flag.
- chrono_done  out  1  sticky countdown-finished flag.

Behaviour:
- Reset, on an edge with rst=1:
  - prescaler=0; clock=00:00:00; stopwatch=00:00:00; alarm regs=00:00.
  - alarm=0, chrono_done=0, view FSM=R0 (so nrc=1).
  - rst has priority over every other input.
- Prescaler:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - tick = (div_cnt==TICK_DIV-1), combinational.
  - First tick: TICK_DIV-1 edges after rst falls; with TICK_DIV=1, tick is constant 1 outside reset.
- Clock counter, updated on an edge where tick=1:
  - s+1; at s=59 → s=0 and m+1; at m=59 with s=59 → m=0 and h+1.
  - h wraps from HOUR_MOD-1 to 0.
  - All carries resolve in the same edge.
- set_en:
  - Overrides the tick on that edge and loads the set fields.
  - If set_s>59, set_m>59 or set_h>HOUR_MOD-1, the whole load is ignored and the tick still applies.
  - The prescaler is not reset by set_en.
- Stopwatch: updates only on an edge with tick=1 and startstop=1. Priority order:
  - rst, then zera, then the tick.
  - zera clears the value to 00:00:00 and clears chrono_done.
  - Up-count: same carry rules as the clock.
  - Down-count, normal step: s-1, borrowing from m and then h.
  - Down-count at 00:00:00 with CHRONO_STOP_AT_ZERO=0: wraps to HOUR_MOD-1:59:59.
  - Down-count at 00:00:00 with CHRONO_STOP_AT_ZERO=1: value holds and chrono_done is set; it stays set until zera or rst.
  - Down-count landing on 00:00:00 from 00:00:01 with CHRONO_STOP_AT_ZERO=1: chrono_done is set on that same edge.
  - ud may change at any time and takes effect on the next counting edge.
- View FSM (states R0, R1, C0, C1):
  - R0→R1 when rc=1; R1→C0 when rc=0; C0→C1 when rc=1; C1→R0 when rc=0; otherwise hold.
  - nrc=1 in R0/R1.
- Display outputs:
  - nrc=1 selects the clock registers; nrc=0 selects the stopwatch registers.
  - The mux is combinational: zero latency from register to output.
- Alarm registers:
  - alarm_wr loads alarm_h/alarm_m.
  - The write is ignored if alarm_m>59 or alarm_h>HOUR_MOD-1.
- Alarm flag:
  - Sets on a tick-driven clock update whose new value equals alarm_h:alarm_m:00 while alarm_on=1.
  - set_en loads never trigger it.
  - alarm_ack clears it; if set and ack happen on the same edge, set wins.
  - alarm_on=0 does not clear an already-set flag.

Decomposition:
- Shared package clock_pkg holds:
  - the view state enum (R0, R1, C0, C1) and SEC_MAX=59, MIN_MAX=59;
  - a range-check function used by both set_en and alarm_wr.
- One sub-module, hms_counter, parametrised by HOUR_MOD.
  - Inputs: en, up, clr, load, load value.
  - Outputs: h/m/s, at_max, at_zero.
  - Instantiated twice: clock (up=1) and stopwatch.
- Prescaler, view FSM, alarm logic and output mux live in the top module.

Test Plan:
- TICK_DIV=4; release rst → tick on cycles 3, 7, 11; clock reads 00:00:01 after the first tick; nrc=1.
- set_en with 22:59:58 (HOUR_MOD=24), two ticks → 22:59:59 then 23:00:00; load 23:59:59, one tick → 00:00:00; set_s=60 → load ignored.
- Stopwatch: startstop=1, ud=0 from 00:00:00 with CHRONO_STOP_AT_ZERO=0 → 23:59:59; with =1 → holds 00:00:00 and chrono_done=1; zera → done=0.
- rc pulse 1→0 → nrc=0 and outputs show the stopwatch; a second press/release → nrc=1; holding rc=1 keeps the state R1.
- alarm_wr 07:30, alarm_on=1, set clock 07:29:59, one tick → alarm=1; alarm_ack → 0; ack on the same edge as a new match → stays 1.
- rst=1 for one edge mid-count with startstop=1 → all counters 00:00:00, nrc=1, alarm=0, chrono_done=0 on the next cycle.
